mem_stage: RTL and testbench

//  Memory-access pipeline stage; consumer of the execute stage's aluOut/rBOut/dmwe/dm_byte/rwe/rwd outputs.

---
 rtl/mips_pkg.sv | 18 +
 rtl/mem_byte_lane.sv | 48 ++++
 rtl/mem_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: memory-stage FSM encoding,
// byte-enable constants and the big-endian byte-lane decode.
package mips_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StReq  = 1'b1
    } mem_state_e;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Big-endian: offset 00 addresses bits [31:24], i.e. byte enable bit 3.
    function automatic logic [3:0] byte_lane(input logic [1:0] off);
        return 4'b1000 >> off;
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane steering for the memory stage: store data
// replication and byte enables on the request side, lane extraction with
// sign/zero extension on the load-return side.
module mem_byte_lane
    import mips_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic        st_byte,
    input  logic [31:0] rb_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    input  logic [1:0]  ld_off,
    input  logic        ld_byte,
    input  logic        ld_unsigned,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0] ld_lane;

    // Store side: a byte store drives the same byte on every lane and lets
    // the enables pick the target.
    always_comb begin
        st_wdata = rb_data;
        st_be    = BE_WORD;
        if (st_byte) begin
            st_wdata = {4{rb_data[7:0]}};
            st_be    = byte_lane(st_off);
        end
    end

    // Load side: pick the addressed lane and extend it to a word.
    always_comb begin
        ld_lane = rdata[31:24];
        unique case (ld_off)
            2'b00: ld_lane = rdata[31:24];
            2'b01: ld_lane = rdata[23:16];
            2'b10: ld_lane = rdata[15:8];
            2'b11: ld_lane = rdata[7:0];
            default: ld_lane = rdata[31:24];
        endcase
        ld_data = rdata;
        if (ld_byte) begin
            ld_data = {{24{ld_lane[7] & ~ld_unsigned}}, ld_lane};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over a req/ack
// handshake, stalls upstream while an access is outstanding, and holds the
// M/W result register that feeds writeback and the WX bypass.
// Optional build macro MEM_STAGE_ALIGN_CHECK_EN: misaligned word accesses
// are not issued and are reported on align_err instead.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       alu_out,
    input  logic [31:0]       rb_data,
    input  logic              dmwe,
    input  logic              rwd,
    input  logic              dm_byte,
    input  logic              ld_unsigned,
    input  logic              rwe,
    input  logic [4:0]        rd_addr,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    output logic [3:0]        dm_be,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata,
    output logic              wb_valid,
    output logic              wb_rwe,
    output logic [4:0]        wb_waddr,
    output logic [31:0]       wb_data,
    output logic              dm_timeout
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    ,
    output logic              align_err
`endif
);

    localparam int unsigned CntW = $clog2(WAIT_MAX + 1);

    mem_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              ld_byte_q, ld_byte_d;
    logic              ld_uns_q, ld_uns_d;
    logic              rwd_q, rwd_d;
    logic              rwe_q, rwe_d;
    logic [4:0]        rd_q, rd_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_rwe_q, wb_rwe_d;
    logic [4:0]        wb_waddr_q, wb_waddr_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              timeout_q, timeout_d;
    logic              align_q, align_d;

    logic              mem_op;
    logic              misaligned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       st_wdata;
    logic [3:0]        st_be;
    logic [31:0]       ld_data;

    assign mem_op = dmwe | rwd;

    mem_byte_lane u_lane (
        .st_off      (alu_out[1:0]),
        .st_byte     (dm_byte),
        .rb_data     (rb_data),
        .st_wdata    (st_wdata),
        .st_be       (st_be),
        .ld_off      (addr_q[1:0]),
        .ld_byte     (ld_byte_q),
        .ld_unsigned (ld_uns_q),
        .rdata       (dm_rdata),
        .ld_data     (ld_data)
    );

    // Request address: word accesses always go out word-aligned.
    always_comb begin
        req_addr = alu_out[ADDR_W-1:0];
        if (!dm_byte) begin
            req_addr[1:0] = 2'b00;
        end
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        misaligned = ~dm_byte & (alu_out[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
    end

    // Next-state: FSM, wait counter, request latch and W register.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        ld_byte_d  = ld_byte_q;
        ld_uns_d   = ld_uns_q;
        rwd_d      = rwd_q;
        rwe_d      = rwe_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rwe_d   = 1'b0;
        wb_waddr_d = wb_waddr_q;
        wb_data_d  = wb_data_q;
        timeout_d  = 1'b0;
        align_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_valid && !mem_op) begin
                    wb_valid_d = 1'b1;
                    wb_rwe_d   = rwe;
                    wb_waddr_d = rd_addr;
                    wb_data_d  = alu_out;
                end else if (in_valid && misaligned) begin
                    // Retire without touching memory or the register file.
                    wb_valid_d = 1'b1;
                    wb_waddr_d = rd_addr;
                    align_d    = 1'b1;
                end else if (in_valid) begin
                    state_d   = StReq;
                    cnt_d     = '0;
                    addr_d    = req_addr;
                    we_d      = dmwe;
                    wdata_d   = st_wdata;
                    be_d      = st_be;
                    ld_byte_d = dm_byte;
                    ld_uns_d  = ld_unsigned;
                    rwd_d     = rwd;
                    rwe_d     = rwe;
                    rd_d      = rd_addr;
                end
            end
            StReq: begin
                if (dm_ack) begin
                    state_d    = StIdle;
                    wb_valid_d = 1'b1;
                    wb_rwe_d   = rwe_q & ~we_q;
                    wb_waddr_d = rd_q;
                    wb_data_d  = rwd_q ? ld_data : 32'h0;
                end else if (cnt_q == CntW'(WAIT_MAX)) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset abandons any outstanding access.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0;
            be_q       <= BE_NONE;
            ld_byte_q  <= 1'b0;
            ld_uns_q   <= 1'b0;
            rwd_q      <= 1'b0;
            rwe_q      <= 1'b0;
            rd_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_rwe_q   <= 1'b0;
            wb_waddr_q <= 5'd0;
            wb_data_q  <= 32'h0;
            timeout_q  <= 1'b0;
            align_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            ld_byte_q  <= ld_byte_d;
            ld_uns_q   <= ld_uns_d;
            rwd_q      <= rwd_d;
            rwe_q      <= rwe_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rwe_q   <= wb_rwe_d;
            wb_waddr_q <= wb_waddr_d;
            wb_data_q  <= wb_data_d;
            timeout_q  <= timeout_d;
            align_q    <= align_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign dm_req     = (state_q == StReq);
    assign dm_we      = we_q;
    assign dm_addr    = addr_q;
    assign dm_wdata   = wdata_q;
    assign dm_be      = be_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rwe     = wb_rwe_q;
    assign wb_waddr   = wb_waddr_q;
    assign wb_data    = wb_data_q;
    assign dm_timeout = timeout_q;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign align_err  = align_q;
`else
    // Without the alignment check the pulse has no consumer.
    logic unused_align;
    assign unused_align = align_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage (WAIT_MAX overridden to 4).
module tb_mem_stage;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_out;
    logic [31:0] rb_data;
    logic        dmwe;
    logic        rwd;
    logic        dm_byte;
    logic        ld_unsigned;
    logic        rwe;
    logic [4:0]  rd_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        wb_valid;
    logic        wb_rwe;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_data;
    logic        dm_timeout;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    logic        align_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(
        .ADDR_W   (32),
        .WAIT_MAX (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_out     (alu_out),
        .rb_data     (rb_data),
        .dmwe        (dmwe),
        .rwd         (rwd),
        .dm_byte     (dm_byte),
        .ld_unsigned (ld_unsigned),
        .rwe         (rwe),
        .rd_addr     (rd_addr),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_be       (dm_be),
        .dm_ack      (dm_ack),
        .dm_rdata    (dm_rdata),
        .wb_valid    (wb_valid),
        .wb_rwe      (wb_rwe),
        .wb_waddr    (wb_waddr),
        .wb_data     (wb_data),
        .dm_timeout  (dm_timeout)
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        ,
        .align_err   (align_err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] rb, input logic we,
                         input logic ld, input logic byt, input logic uns, input logic wen,
                         input logic [4:0] rd);
        in_valid = 1'b1; alu_out = addr; rb_data = rb; dmwe = we; rwd = ld;
        dm_byte = byt; ld_unsigned = uns; rwe = wen; rd_addr = rd;
    endtask

    // Accept a memory op, then ack it after 'waits' idle REQ cycles.
    // Returns the request as seen on the bus and how many cycles in_ready was low.
    task automatic issue(input logic [31:0] addr, input logic [31:0] rb, input logic we,
                         input logic ld, input logic byt, input logic uns, input logic [4:0] rd,
                         input int waits, input logic [31:0] rdata,
                         output logic [31:0] o_addr, output logic [31:0] o_wdata,
                         output logic [3:0] o_be, output logic o_we, output int busy);
        drive(addr, rb, we, ld, byt, uns, 1'b1, rd);
        tick();
        in_valid = 1'b0;
        o_addr = dm_addr; o_wdata = dm_wdata; o_be = dm_be; o_we = dm_we;
        busy = 0;
        for (int i = 0; i <= waits; i++) begin
            if (in_ready === 1'b0 && dm_req === 1'b1) busy++;
            dm_ack = (i == waits);
            dm_rdata = rdata;
            tick();
        end
        dm_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        n_checks++;
        if ({dm_req, dm_we, wb_valid, wb_rwe, dm_timeout} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 00000",
                               {dm_req, dm_we, wb_valid, wb_rwe, dm_timeout});
        end
        n_checks++;
        if ({dm_addr, dm_wdata, wb_data, dm_be, wb_waddr} !== 105'b0) begin
            n_fail++; $display("FAIL reset_data: addr %h wdata %h wb_data %h be %h waddr %h",
                               dm_addr, dm_wdata, wb_data, dm_be, wb_waddr);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b required 1", in_ready);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_pass();
        drive(32'h1234, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({wb_valid, wb_rwe, wb_waddr, wb_data} !== {1'b1, 1'b1, 5'd5, 32'h1234}) begin
            n_fail++; $display("FAIL alu_wb: got v%b rwe%b a%0d d%h required v1 rwe1 a5 d1234",
                               wb_valid, wb_rwe, wb_waddr, wb_data);
        end
        n_checks++;
        if (in_ready !== 1'b1 || dm_req !== 1'b0) begin
            n_fail++; $display("FAIL alu_ready: ready %b req %b required 1 0", in_ready, dm_req);
        end
        tick();
        n_checks++;
        if (wb_valid !== 1'b0 || wb_rwe !== 1'b0) begin
            n_fail++; $display("FAIL alu_pulse: wb_valid %b wb_rwe %b required 0 0",
                               wb_valid, wb_rwe);
        end
    endtask

    task automatic test_back_to_back();
        drive(32'hA5A5_0001, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1);
        tick();
        drive(32'h5A5A_0002, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2);
        n_checks++;
        if ({wb_valid, wb_data, wb_waddr} !== {1'b1, 32'hA5A5_0001, 5'd1}) begin
            n_fail++; $display("FAIL b2b_first: v%b d%h a%0d required v1 dA5A50001 a1",
                               wb_valid, wb_data, wb_waddr);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({wb_valid, wb_rwe, wb_data, wb_waddr} !== {1'b1, 1'b0, 32'h5A5A_0002, 5'd2}) begin
            n_fail++; $display("FAIL b2b_second: v%b rwe%b d%h a%0d required v1 rwe0 d5A5A0002 a2",
                               wb_valid, wb_rwe, wb_data, wb_waddr);
        end
        tick();
    endtask

    task automatic test_lw();
        logic [31:0] a, wd; logic [3:0] be; logic we; int busy;
        issue(32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 3, 32'hDEAD_BEEF, a, wd, be, we, busy);
        n_checks++;
        if (busy !== 4) begin
            n_fail++; $display("FAIL lw_stall: in_ready low %0d cycles required 4", busy);
        end
        n_checks++;
        if ({a, be, we} !== {32'h100, 4'hF, 1'b0}) begin
            n_fail++; $display("FAIL lw_req: addr %h be %h we %b required 100 f 0", a, be, we);
        end
        n_checks++;
        if ({wb_valid, wb_rwe, wb_waddr, wb_data} !== {1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL lw_wb: v%b rwe%b a%0d d%h required v1 rwe1 a7 dDEADBEEF",
                               wb_valid, wb_rwe, wb_waddr, wb_data);
        end
        n_checks++;
        if (in_ready !== 1'b1 || dm_req !== 1'b0) begin
            n_fail++; $display("FAIL lw_done: ready %b req %b required 1 0", in_ready, dm_req);
        end
        tick();
    endtask

    task automatic test_byte_load();
        logic [31:0] a, wd; logic [3:0] be; logic we; int busy;
        issue(32'h101, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 0, 32'h11F2_3344, a, wd, be, we, busy);
        n_checks++;
        if ({a, be} !== {32'h101, 4'b0100}) begin
            n_fail++; $display("FAIL lb_req: addr %h be %b required 101 0100", a, be);
        end
        n_checks++;
        if ({wb_valid, wb_data} !== {1'b1, 32'hFFFF_FFF2}) begin
            n_fail++; $display("FAIL lb_data: v%b d%h required v1 dFFFFFFF2", wb_valid, wb_data);
        end
        tick();
        issue(32'h101, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 1, 32'h11F2_3344, a, wd, be, we, busy);
        n_checks++;
        if ({wb_valid, wb_data} !== {1'b1, 32'h0000_00F2}) begin
            n_fail++; $display("FAIL lbu_data: v%b d%h required v1 d000000F2", wb_valid, wb_data);
        end
        tick();
        // Lane 11 with a positive byte: no sign fill.
        issue(32'h203, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 0, 32'h8081_8244, a, wd, be, we, busy);
        n_checks++;
        if ({be, wb_data} !== {4'b0001, 32'h0000_0044}) begin
            n_fail++; $display("FAIL lb_lane3: be %b d%h required 0001 d00000044", be, wb_data);
        end
        tick();
    endtask

    task automatic test_sb();
        logic [31:0] a, wd; logic [3:0] be; logic we; int busy;
        issue(32'h103, 32'h0000_00AB, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 2, 32'h0, a, wd, be, we, busy);
        n_checks++;
        if ({we, be, wd, a} !== {1'b1, 4'b0001, 32'hABAB_ABAB, 32'h103}) begin
            n_fail++; $display("FAIL sb_req: we %b be %b wdata %h addr %h required 1 0001 ABABABAB 103",
                               we, be, wd, a);
        end
        n_checks++;
        if ({wb_valid, wb_rwe} !== 2'b10) begin
            n_fail++; $display("FAIL sb_retire: v%b rwe%b required v1 rwe0", wb_valid, wb_rwe);
        end
        tick();
        issue(32'h300, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 0, 32'h0, a, wd, be, we, busy);
        n_checks++;
        if ({we, be, wd} !== {1'b1, 4'hF, 32'hCAFE_F00D}) begin
            n_fail++; $display("FAIL sw_req: we %b be %h wdata %h required 1 f CAFEF00D", we, be, wd);
        end
        tick();
    endtask

    task automatic test_ack_idle();
        int wb_seen = 0;
        dm_ack = 1'b1;
        dm_rdata = 32'h1357_9BDF;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wb_valid === 1'b1) wb_seen++;
        end
        dm_ack = 1'b0;
        n_checks++;
        if (wb_seen !== 0) begin
            n_fail++; $display("FAIL ack_idle: %0d writebacks required 0", wb_seen);
        end
    endtask

    task automatic test_timeout();
        int to_cnt = 0;
        int wb_seen = 0;
        drive(32'h200, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dm_timeout === 1'b1) to_cnt++;
            if (wb_valid === 1'b1) wb_seen++;
            tick();
        end
        n_checks++;
        if (to_cnt !== 1) begin
            n_fail++; $display("FAIL timeout_pulse: %0d pulses required 1", to_cnt);
        end
        n_checks++;
        if (wb_seen !== 0 || dm_req !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL timeout_end: wb %0d req %b ready %b required 0 0 1",
                               wb_seen, dm_req, in_ready);
        end
    endtask

    task automatic test_reset_mid_req();
        int wb_seen = 0;
        drive(32'h400, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (dm_req !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre: dm_req %b required 1", dm_req);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (dm_req !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_async: dm_req %b ready %b required 0 1", dm_req, in_ready);
        end
        dm_ack = 1'b1;
        dm_rdata = 32'hFFFF_0000;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wb_valid === 1'b1) wb_seen++;
        end
        dm_ack = 1'b0;
        n_checks++;
        if (wb_seen !== 0) begin
            n_fail++; $display("FAIL rst_abandon: %0d writebacks required 0", wb_seen);
        end
    endtask

    task automatic test_misaligned();
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        drive(32'h102, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd10);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL align_ready: got %b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({dm_req, align_err, wb_valid, wb_rwe, in_ready} !== 5'b01101) begin
            n_fail++; $display("FAIL align_err: req %b err %b v %b rwe %b ready %b required 0 1 1 0 1",
                               dm_req, align_err, wb_valid, wb_rwe, in_ready);
        end
        tick();
        n_checks++;
        if (align_err !== 1'b0 || dm_req !== 1'b0) begin
            n_fail++; $display("FAIL align_pulse: err %b req %b required 0 0", align_err, dm_req);
        end
`else
        logic [31:0] a, wd; logic [3:0] be; logic we; int busy;
        issue(32'h102, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd10, 0, 32'h2468_ACE0, a, wd, be, we, busy);
        n_checks++;
        if ({a, be} !== {32'h100, 4'hF}) begin
            n_fail++; $display("FAIL align_force: addr %h be %h required 100 f", a, be);
        end
        n_checks++;
        if ({wb_valid, wb_data} !== {1'b1, 32'h2468_ACE0}) begin
            n_fail++; $display("FAIL align_wb: v%b d%h required v1 d2468ACE0", wb_valid, wb_data);
        end
`endif
        tick();
    endtask

    initial begin
        in_valid = 1'b0; alu_out = 32'h0; rb_data = 32'h0; dmwe = 1'b0; rwd = 1'b0;
        dm_byte = 1'b0; ld_unsigned = 1'b0; rwe = 1'b0; rd_addr = 5'd0;
        dm_ack = 1'b0; dm_rdata = 32'h0; reset_n = 1'b0;
        test_reset();
        test_alu_pass();
        test_back_to_back();
        test_lw();
        test_byte_load();
        test_sb();
        test_ack_idle();
        test_timeout();
        test_reset_mid_req();
        test_misaligned();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
